// File: rtl/reg_file_scoreboard.sv
// General-purpose register file with one write port, two registered read ports,
// R0 base-address zeroing on port A and a per-register pending-write scoreboard.
module reg_file_scoreboard #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter bit                    R0_BA_ZERO = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  BAOut,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  rd_ready_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_ready_b
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Declaration initialisers give the power-up state; clear never restores INIT.
    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS] = '{default: INIT};
    logic [NUM_REGS-1:0]   pending_reg         = '0;
    logic [NUM_REGS-1:0]   pending_next;

    logic [DATA_WIDTH-1:0] rd_data_a_reg  = '0;
    logic [DATA_WIDTH-1:0] rd_data_b_reg  = '0;
    logic                  rd_ready_a_reg = 1'b1;
    logic                  rd_ready_b_reg = 1'b1;
    logic [DATA_WIDTH-1:0] rd_data_a_next;
    logic [DATA_WIDTH-1:0] rd_data_b_next;

    // Reserve wins over a same-cycle write to the same register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            assign pending_next[gi] =
                (rsv_en && (rsv_addr == ADDR_WIDTH'(gi))) ||
                (pending_reg[gi] && !(wr_en && (wr_addr == ADDR_WIDTH'(gi))));
        end
    endgenerate

    always_comb begin
        rd_data_a_next = regs_reg[rd_addr_a];
        rd_data_b_next = regs_reg[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a_next = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b_next = wr_data;
        end
        // Base-address zeroing overrides even the write bypass.
        if (R0_BA_ZERO && BAOut && (rd_addr_a == '0)) begin
            rd_data_a_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            pending_reg    <= '0;
            rd_data_a_reg  <= '0;
            rd_data_b_reg  <= '0;
            rd_ready_a_reg <= 1'b1;
            rd_ready_b_reg <= 1'b1;
        end else begin
            if (wr_en) begin
                regs_reg[wr_addr] <= wr_data;
            end
            pending_reg    <= pending_next;
            rd_data_a_reg  <= rd_data_a_next;
            rd_data_b_reg  <= rd_data_b_next;
            rd_ready_a_reg <= ~pending_next[rd_addr_a];
            rd_ready_b_reg <= ~pending_next[rd_addr_b];
        end
    end

    assign rd_data_a  = rd_data_a_reg;
    assign rd_data_b  = rd_data_b_reg;
    assign rd_ready_a = rd_ready_a_reg;
    assign rd_ready_b = rd_ready_b_reg;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios plus a random
// back-to-back run against a small behavioural model, via an expectation queue.
module tb_reg_file_scoreboard;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'h0;
    logic        rsv_en = 1'b0;
    logic [3:0]  rsv_addr = 4'd0;
    logic [3:0]  rd_addr_a = 4'd4;
    logic        BAOut = 1'b0;
    logic [3:0]  rd_addr_b = 4'd4;
    logic [31:0] rd_data_a, rd_data_b, nz_data_a, nz_data_b;
    logic        rd_ready_a, rd_ready_b, nz_ready_a, nz_ready_b;

    always #5 clock = ~clock;

    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .INIT(32'hCAFE0000), .R0_BA_ZERO(1'b1)) dut (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr_a(rd_addr_a), .BAOut(BAOut),
        .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_ready_a(rd_ready_a),
        .rd_data_b(rd_data_b), .rd_ready_b(rd_ready_b)
    );

    // Second instance with base-address zeroing disabled, sharing all inputs.
    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .INIT(32'h0), .R0_BA_ZERO(1'b0)) dut_nz (
        .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr_a(rd_addr_a), .BAOut(BAOut),
        .rd_addr_b(rd_addr_b), .rd_data_a(nz_data_a), .rd_ready_a(nz_ready_a),
        .rd_data_b(nz_data_b), .rd_ready_b(nz_ready_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] da;
        logic        ra;
        logic [31:0] db;
        logic        rb;
        logic [31:0] nza;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    task automatic drive(input logic clr, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic rs, input logic [3:0] rsa, input logic [3:0] ra,
                         input logic ba, input logic [3:0] rb);
        clear = clr; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = rs; rsv_addr = rsa; rd_addr_a = ra; BAOut = ba; rd_addr_b = rb;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_powerup;
        vectors++;
        if (rd_data_a !== 32'h0 || rd_ready_a !== 1'b1 || rd_data_b !== 32'h0 || rd_ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL powerup_idle: got a=%h/%b b=%h/%b, expected a=00000000/1 b=00000000/1",
                     rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
        sb_q.push_back('{"powerup_read4", 32'hCAFE0000, 1'b1, 32'hCAFE0000, 1'b1, 32'h0});
        tick;
        e = sb_q.pop_front();
        vectors++;
        if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
            miscompares++;
            $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                     rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
        end
        $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            case (k)
                0: begin
                    drive(1'b1, 1'b1, 4'd4, 32'h11111111, 1'b1, 4'd4, 4'd4, 1'b0, 4'd4);
                    sb_q.push_back('{"reset_edge", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
                default: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 1'b0, 4'd4);
                    sb_q.push_back('{"reset_read4", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
    endtask

    task automatic test_write_read;
        for (int k = 0; k < 2; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd1, 1'b0, 4'd2);
                    sb_q.push_back('{"wr5_read12", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
                default: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 1'b0, 4'd5);
                    sb_q.push_back('{"read5", 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
    endtask

    task automatic test_baout;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b1, 4'd0, 32'h1234, 1'b0, 4'd0, 4'd6, 1'b0, 4'd6);
                    sb_q.push_back('{"wr0_read6", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
                1: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0);
                    sb_q.push_back('{"baout_r0", 32'h0, 1'b1, 32'h1234, 1'b1, 32'h1234});
                end
                2: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
                    sb_q.push_back('{"no_baout_r0", 32'h1234, 1'b1, 32'h1234, 1'b1, 32'h1234});
                end
                3: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 1'b1, 4'd0);
                    sb_q.push_back('{"baout_r5", 32'hDEADBEEF, 1'b1, 32'h1234, 1'b1, 32'hDEADBEEF});
                end
                default: begin
                    drive(1'b0, 1'b1, 4'd0, 32'h55, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0);
                    sb_q.push_back('{"baout_bypass_r0", 32'h0, 1'b1, 32'h55, 1'b1, 32'h55});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            vectors++;
            if (nz_data_a !== e.nza || nz_ready_a !== e.ra || nz_data_b !== e.db || nz_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s_nozero: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         nz_data_a, nz_ready_a, nz_data_b, nz_ready_b, e.nza, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b nz_a=%h", e.tag, rd_data_a, rd_ready_a,
                     rd_data_b, rd_ready_b, nz_data_a);
        end
    endtask

    task automatic test_reserve_bypass;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd3, 1'b0, 4'd3);
                    sb_q.push_back('{"rsv3_read3", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
                end
                1: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 1'b0, 4'd3);
                    sb_q.push_back('{"read3_pending", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
                end
                2: begin
                    drive(1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd3, 1'b0, 4'd3);
                    sb_q.push_back('{"wr3_bypass", 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h0});
                end
                default: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 1'b0, 4'd3);
                    sb_q.push_back('{"read3_done", 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h0});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
    endtask

    task automatic test_wr_rsv_same;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 4'd7, 1'b0, 4'd7);
                    sb_q.push_back('{"wr_rsv7", 32'h77, 1'b0, 32'h77, 1'b0, 32'h0});
                end
                1: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 1'b0, 4'd7);
                    sb_q.push_back('{"read7_pending", 32'h77, 1'b0, 32'h77, 1'b0, 32'h0});
                end
                2: begin
                    drive(1'b0, 1'b1, 4'd8, 32'h88, 1'b1, 4'd10, 4'd8, 1'b0, 4'd10);
                    sb_q.push_back('{"wr8_rsv10", 32'h88, 1'b1, 32'h0, 1'b0, 32'h0});
                end
                default: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd10, 1'b0, 4'd8);
                    sb_q.push_back('{"read10_8", 32'h0, 1'b0, 32'h88, 1'b1, 32'h0});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
    endtask

    task automatic test_clear_mid;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 4'd2, 1'b0, 4'd9);
                    sb_q.push_back('{"rsv2", 32'h0, 1'b0, 32'h0, 1'b1, 32'h0});
                end
                1: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd2, 1'b0, 4'd9);
                    sb_q.push_back('{"rsv9", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0});
                end
                2: begin
                    drive(1'b1, 1'b1, 4'd2, 32'hFF, 1'b1, 4'd9, 4'd2, 1'b0, 4'd9);
                    sb_q.push_back('{"clear_over_wr_rsv", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
                3: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 1'b0, 4'd9);
                    sb_q.push_back('{"read2_9_cleared", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
                default: begin
                    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 1'b0, 4'd7);
                    sb_q.push_back('{"read5_7_cleared", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
                end
            endcase
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] m_regs [16];
        logic [15:0] m_pend;
        logic        we, rs, ba;
        logic [3:0]  wa, rsa, ra, rb;
        logic [31:0] wd, xa, xb;
        logic        ya, yb;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_pend = 16'h0;
        for (int k = 0; k < 121; k++) begin
            if (k == 0) begin
                we = 1'b0; wa = 4'd0; wd = 32'h0; rs = 1'b0; rsa = 4'd0; ba = 1'b0; ra = 4'd0; rb = 4'd0;
                drive(1'b1, we, wa, wd, rs, rsa, ra, ba, rb);
                sb_q.push_back('{"b2b_clear", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0});
            end else begin
                we  = 1'($urandom_range(0, 1));
                wa  = 4'($urandom_range(0, 7));
                wd  = $urandom;
                rs  = ($urandom_range(0, 3) == 0);
                rsa = 4'($urandom_range(0, 7));
                ra  = 4'($urandom_range(0, 7));
                rb  = 4'($urandom_range(0, 7));
                ba  = ($urandom_range(0, 3) == 0);
                xa = (we && wa == ra) ? wd : m_regs[ra];
                if (ba && ra == 4'd0) xa = 32'h0;
                xb = (we && wa == rb) ? wd : m_regs[rb];
                ya = !((rs && rsa == ra) || (m_pend[ra] && !(we && wa == ra)));
                yb = !((rs && rsa == rb) || (m_pend[rb] && !(we && wa == rb)));
                if (we) begin
                    m_regs[wa] = wd;
                    m_pend[wa] = 1'b0;
                end
                if (rs) m_pend[rsa] = 1'b1;
                drive(1'b0, we, wa, wd, rs, rsa, ra, ba, rb);
                sb_q.push_back('{$sformatf("b2b_%0d", k), xa, ya, xb, yb, 32'h0});
            end
            tick;
            e = sb_q.pop_front();
            vectors++;
            if (rd_data_a !== e.da || rd_ready_a !== e.ra || rd_data_b !== e.db || rd_ready_b !== e.rb) begin
                miscompares++;
                $display("FAIL %s: got a=%h/%b b=%h/%b, expected a=%h/%b b=%h/%b", e.tag,
                         rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, e.da, e.ra, e.db, e.rb);
            end
            $display("txn %s: a=%h/%b b=%h/%b", e.tag, rd_data_a, rd_ready_a, rd_data_b, rd_ready_b);
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        #1;
        test_powerup;
        test_reset;
        test_write_read;
        test_baout;
        test_reserve_bypass;
        test_wr_rsv_same;
        test_clear_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
